// File: rtl/paralelo_serial_tx_if.sv
// ---------------------------------------------------------------------------
// paralelo_serial_tx_if
// Byte-side link between the 4-lane byte multiplexer (master) and the serial
// transmitter (slave).
//   data_in  : byte presented by the multiplexer
//   valid_in : data_in qualifier
//   byte_req : strobe from the transmitter; the byte on data_in/valid_in is
//              sampled on the rising clock edge that ends this cycle
// ---------------------------------------------------------------------------
interface paralelo_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       byte_req;

    modport master (
        output data_in,
        output valid_in,
        input  byte_req
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output byte_req
    );
endinterface

// File: rtl/paralelo_serial_tx.sv
// ---------------------------------------------------------------------------
// paralelo_serial_tx
// Final serialization stage of the transmit PHY. Runs on the bit clock (8x
// the byte clock) and shifts out one bit per clock, MSB first. After reset a
// preamble of INIT_COMS COM symbols is sent so the far end can align; once
// active, any byte presented without valid_in is replaced by COM.
//
// Ports:
//   clk      : bit clock, all state updates on its rising edge
//   reset_L  : asynchronous active-low reset
//   up       : byte interface (slave side) - data_in, valid_in, byte_req
//   data_out : serial bit stream, MSB of each byte first
//   active   : high once the preamble is complete and user data is accepted
// ---------------------------------------------------------------------------
module paralelo_serial_tx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned INIT_COMS = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    paralelo_serial_tx_if.slave   up,
    output logic                  data_out,
    output logic                  active
);

    typedef enum logic {
        INIT   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COM = 4'(INIT_COMS - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] com_cnt_q;
    logic [3:0] com_cnt_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       byte_req_q;
    logic [7:0] next_byte;

    // Byte selection: COM during the preamble, otherwise the upstream byte
    // when it is valid and COM as filler when it is not.
    function automatic logic [7:0] pick_byte(input state_t st,
                                             input logic   vld,
                                             input logic [7:0] dat);
        if (st == ACTIVE && vld) begin
            return dat;
        end
        return COM;
    endfunction

    // Bit counter and byte strobe. byte_req is kept as its own flop (set one
    // edge ahead, when the counter is about to reach 7) so the output is a
    // clean register output instead of a decode of three counter bits. It is
    // always equal to (bit_cnt_q == 7).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bit_cnt_q  <= 3'd0;
            byte_req_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            byte_req_q <= (bit_cnt_q == 3'd6);
        end
    end

    // Shift register: load on the byte strobe, otherwise shift left so the
    // MSB leaves first. A reset mid-byte simply discards what was in flight.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            shreg_q <= 8'h00;
        end else if (byte_req_q) begin
            shreg_q <= next_byte;
        end else begin
            shreg_q <= {shreg_q[6:0], 1'b0};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= INIT;
            com_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
        end
    end

    // FSM next-state logic. Inputs only matter on byte_req cycles, since
    // both next_byte and the preamble count are consumed only on loads.
    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        next_byte = pick_byte(state_q, up.valid_in, up.data_in);
        case (state_q)
            INIT: begin
                if (byte_req_q) begin
                    com_cnt_d = com_cnt_q + 4'd1;
                    if (com_cnt_q == LAST_COM) begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign up.byte_req = byte_req_q;
    assign data_out    = shreg_q[7];
    assign active      = (state_q == ACTIVE);

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_paralelo_serial_tx
// Bench for paralelo_serial_tx. dut1 uses the default COM/INIT_COMS = BC/4,
// dut2 uses 7C/1. A table of byte records drives dut1 through the preamble,
// data ordering, filler, off-strobe glitches and a mid-byte reset; expected
// bits are queued when a byte is driven and popped one per clock.
// ---------------------------------------------------------------------------
module tb_paralelo_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_L;
    logic reset2_L;
    logic data_out1;
    logic active1;
    logic data_out2;
    logic active2;

    paralelo_serial_tx_if bus1 ();
    paralelo_serial_tx_if bus2 ();

    paralelo_serial_tx #(.COM(8'hBC), .INIT_COMS(4)) dut1 (
        .clk      (clk),
        .reset_L  (reset_L),
        .up       (bus1),
        .data_out (data_out1),
        .active   (active1)
    );

    paralelo_serial_tx #(.COM(8'h7C), .INIT_COMS(1)) dut2 (
        .clk      (clk),
        .reset_L  (reset2_L),
        .up       (bus2),
        .data_out (data_out2),
        .active   (active2)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic       exp_active;
        logic       glitch;
    } vec_t;

    vec_t tbl [0:18];

    int   checks   = 0;
    int   failures = 0;
    bit   exp_q[$];
    int   bit_pos;
    logic exp_active;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic set_vec(input int i, input logic v, input logic [7:0] d,
                           input logic [7:0] e, input logic a, input logic g);
        tbl[i].valid      = v;
        tbl[i].data       = d;
        tbl[i].exp_byte   = e;
        tbl[i].exp_active = a;
        tbl[i].glitch     = g;
    endtask

    // Called at a falling edge right after reset release. Runs the zero byte
    // plus entries lo..hi; the last entry is observed for 'tail' bits only.
    task automatic run_table(input int lo, input int hi, input int tail);
        int   idx;
        int   ncyc;
        logic glitch;
        logic act_next;
        bit   loaded;
        bit   expb;
        idx      = lo;
        ncyc     = 8 + 8 * (hi - lo) + tail;
        glitch   = 1'b0;
        act_next = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 8'd1, 8'd0);
                expb = 1'b0;
            end else begin
                expb = exp_q.pop_front();
            end
            chk($sformatf("data_out[e%0d c%0d]", idx, c), {7'd0, data_out1}, {7'd0, expb});
            chk($sformatf("byte_req[c%0d]", c), {7'd0, bus1.byte_req}, {7'd0, (bit_pos == 7)});
            chk($sformatf("active[c%0d]", c), {7'd0, active1}, {7'd0, exp_active});
            loaded = 1'b0;
            if (bit_pos == 7) begin
                if (idx <= hi) begin
                    bus1.valid_in = tbl[idx].valid;
                    bus1.data_in  = tbl[idx].data;
                    push_byte(tbl[idx].exp_byte);
                    act_next = tbl[idx].exp_active;
                    glitch   = (idx < hi) ? tbl[idx + 1].glitch : 1'b0;
                    idx++;
                end else begin
                    bus1.valid_in = 1'b0;
                    bus1.data_in  = 8'h00;
                    act_next      = exp_active;
                    glitch        = 1'b0;
                end
                loaded = 1'b1;
            end else if (glitch) begin
                bus1.data_in = (c % 2 == 1) ? 8'hFF : 8'h00;
            end
            @(negedge clk);
            bit_pos = (bit_pos + 1) % 8;
            if (loaded) exp_active = act_next;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] eb;

        // Preamble: inputs ignored while INIT
        set_vec(0,  1'b1, 8'hFF, 8'hBC, 1'b0, 1'b0);
        set_vec(1,  1'b1, 8'hFF, 8'hBC, 1'b0, 1'b0);
        set_vec(2,  1'b1, 8'hFF, 8'hBC, 1'b0, 1'b0);
        set_vec(3,  1'b1, 8'hFF, 8'hBC, 1'b1, 1'b0);
        // First user byte, ordering, filler, glitch, valid COM, truncated byte
        set_vec(4,  1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        set_vec(5,  1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0);
        set_vec(6,  1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0);
        set_vec(7,  1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        set_vec(8,  1'b0, 8'h55, 8'hBC, 1'b1, 1'b0);
        set_vec(9,  1'b1, 8'h55, 8'h55, 1'b1, 1'b0);
        set_vec(10, 1'b1, 8'h81, 8'h81, 1'b1, 1'b1);
        set_vec(11, 1'b1, 8'hBC, 8'hBC, 1'b1, 1'b1);
        set_vec(12, 1'b1, 8'hF0, 8'hF0, 1'b1, 1'b0);
        // After mid-byte reset: full preamble again, then data
        set_vec(13, 1'b1, 8'hC3, 8'hBC, 1'b0, 1'b0);
        set_vec(14, 1'b1, 8'hC3, 8'hBC, 1'b0, 1'b1);
        set_vec(15, 1'b1, 8'hC3, 8'hBC, 1'b0, 1'b0);
        set_vec(16, 1'b1, 8'hC3, 8'hBC, 1'b1, 1'b0);
        set_vec(17, 1'b0, 8'hC3, 8'hBC, 1'b1, 1'b0);
        set_vec(18, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0);

        reset_L       = 1'b0;
        reset2_L      = 1'b0;
        bus1.valid_in = 1'b0;
        bus1.data_in  = 8'h00;
        bus2.valid_in = 1'b0;
        bus2.data_in  = 8'h00;
        repeat (3) @(negedge clk);

        chk("reset data_out", {7'd0, data_out1}, 8'd0);
        chk("reset byte_req", {7'd0, bus1.byte_req}, 8'd0);
        chk("reset active", {7'd0, active1}, 8'd0);

        // Run 1: preamble and data, ends 3 bits into 8'hF0
        reset_L    = 1'b1;
        bit_pos    = 0;
        exp_active = 1'b0;
        exp_q.delete();
        push_byte(8'h00);
        run_table(0, 12, 3);

        // Mid-byte reset acts without a clock edge
        reset_L = 1'b0;
        #1;
        chk("midreset data_out", {7'd0, data_out1}, 8'd0);
        chk("midreset byte_req", {7'd0, bus1.byte_req}, 8'd0);
        chk("midreset active", {7'd0, active1}, 8'd0);
        repeat (2) @(negedge clk);

        // Run 2: preamble repeats in full
        reset_L    = 1'b1;
        bit_pos    = 0;
        exp_active = 1'b0;
        exp_q.delete();
        push_byte(8'h00);
        run_table(13, 18, 8);

        // dut2: COM=7C, INIT_COMS=1
        bus2.valid_in = 1'b1;
        bus2.data_in  = 8'h3C;
        reset2_L      = 1'b1;
        for (int c = 0; c < 24; c++) begin
            eb = (c < 8) ? 8'h00 : ((c < 16) ? 8'h7C : 8'h3C);
            chk($sformatf("dut2 data_out[c%0d]", c), {7'd0, data_out2}, {7'd0, eb[7 - (c % 8)]});
            chk($sformatf("dut2 active[c%0d]", c), {7'd0, active2}, {7'd0, (c >= 8)});
            chk($sformatf("dut2 byte_req[c%0d]", c), {7'd0, bus2.byte_req}, {7'd0, (c % 8 == 7)});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
